// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - Hamming(7,4) widths, parity positions and encode function
package hamming_pkg;
    localparam int DATA_W = 4;
    localparam int CODE_W = 7;
    localparam int P0_POS = 0;
    localparam int P1_POS = 1;
    localparam int P3_POS = 3;

    function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        c         = '0;
        c[2]      = d[0];
        c[4]      = d[1];
        c[5]      = d[2];
        c[6]      = d[3];
        c[P0_POS] = d[0] ^ d[1] ^ d[3];
        c[P1_POS] = d[0] ^ d[2] ^ d[3];
        c[P3_POS] = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction
endpackage

// File: rtl/hamming_enc_if.sv
// rtl/hamming_enc_if.sv - nibble input and codeword output handshake bundle
interface hamming_enc_if;
    import hamming_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] d_hamm;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, d_hamm
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, d_hamm
    );
endinterface

// File: rtl/hamming_fifo.sv
// rtl/hamming_fifo.sv - DEPTH-entry codeword FIFO with occupancy count
module hamming_fifo
    import hamming_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [CODE_W-1:0]        wdata_i,
    input  logic                     pop_i,
    output logic [CODE_W-1:0]        rdata_o,
    output logic [$clog2(DEPTH):0]   occ_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       occ_q, occ_d;
    logic [CODE_W-1:0] last_q, last_d;
    logic              push_ok, pop_ok;

    assign full_o  = (occ_q == (AW+1)'(DEPTH));
    assign empty_o = (occ_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        occ_d  = occ_q;
        last_d = last_q;
        if (push_ok) wr_d = wr_q + 1'b1;
        if (pop_ok) begin
            rd_d   = rd_q + 1'b1;
            last_d = mem_q[rd_q];
        end
        if (push_ok && !pop_ok) occ_d = occ_q + 1'b1;
        else if (!push_ok && pop_ok) occ_d = occ_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            occ_q  <= '0;
            last_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            occ_q  <= occ_d;
            last_q <= last_d;
            if (push_ok) mem_q[wr_q] <= wdata_i;
        end
    end

    // When drained, keep presenting the most recently consumed codeword.
    assign rdata_o = empty_o ? last_q : mem_q[rd_q];
    assign occ_o   = occ_q;
endmodule

// File: rtl/hamming_enc.sv
// rtl/hamming_enc.sv - buffered Hamming(7,4) encoder; ERR_INJECT_EN adds err_en/err_pos bit-flip injection
module hamming_enc
    import hamming_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hamming_enc_if.slave           bus,
    output logic [$clog2(DEPTH):0] occ
`ifdef ERR_INJECT_EN
    ,
    input  logic                   err_en,
    input  logic [2:0]             err_pos
`endif
);
    logic [CODE_W-1:0] clean_code;
    logic [CODE_W-1:0] store_code;
    logic              full, empty;

    assign clean_code = hamming_encode(bus.in_data);

`ifdef ERR_INJECT_EN
    // err_pos of 7 lies outside the codeword and means no flip.
    assign store_code = clean_code ^ ((err_en && err_pos != 3'd7) ? (CODE_W'(1) << err_pos) : '0);
`else
    assign store_code = clean_code;
`endif

    hamming_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (bus.in_valid),
        .wdata_i (store_code),
        .pop_i   (bus.out_ready),
        .rdata_o (bus.d_hamm),
        .occ_o   (occ),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
endmodule

// File: tb/tb_hamming_enc.sv
// tb/tb_hamming_enc.sv - directed-vector bench for hamming_enc
module tb_hamming_enc;
    logic       clk;
    logic       rst_n;
    logic [1:0] occ;
`ifdef ERR_INJECT_EN
    logic       err_en;
    logic [2:0] err_pos;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    hamming_enc_if bus ();

    hamming_enc #(.DEPTH(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .occ     (occ)
`ifdef ERR_INJECT_EN
        ,
        .err_en  (err_en),
        .err_pos (err_pos)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed codewords for nibbles 0..F.
    logic [6:0] code_tbl [16] = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
                                  7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] correct(input logic [6:0] c);
        logic [2:0] s;
        logic [6:0] f;
        s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
        s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
        s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
        f = c;
        if (s != 3'd0) f[s - 3'd1] = ~f[s - 3'd1];
        return {f[6], f[5], f[4], f[2]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'h0;
        bus.out_ready = 1'b0;
`ifdef ERR_INJECT_EN
        err_en  = 1'b0;
        err_pos = 3'd7;
`endif
        do_reset();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_occ", 32'(occ), 32'd0);
        check("rst_d_hamm", 32'(bus.d_hamm), 32'h00);

        // Single push of 1011 with consumer ready.
        bus.in_valid = 1'b1; bus.in_data = 4'hB; bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("b_out_valid", 32'(bus.out_valid), 32'd1);
        check("b_d_hamm", 32'(bus.d_hamm), 32'h55);
        check("b_occ", 32'(occ), 32'd1);
        step();
        check("b_drained", 32'(bus.out_valid), 32'd0);
        check("b_hold", 32'(bus.d_hamm), 32'h55);

        // Fill with 0000 and 1111, consumer stalled.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 4'h0; step();
        bus.in_data = 4'hF; step();
        bus.in_data = 4'h8; step();
        bus.in_valid = 1'b0;
        check("full_occ", 32'(occ), 32'd2);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_head", 32'(bus.d_hamm), 32'h00);
        step();
        check("stall_stable", 32'(bus.d_hamm), 32'h00);
        bus.out_ready = 1'b1; step();
        check("pop1", 32'(bus.d_hamm), 32'h7F);
        check("pop1_occ", 32'(occ), 32'd1);
        step();
        check("pop2_empty", 32'(bus.out_valid), 32'd0);
        check("pop2_occ", 32'(occ), 32'd0);

        // Full with push attempt and pop on the same edge.
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        bus.in_data = 4'h3; step();
        bus.in_data = 4'h5; step();
        bus.in_data = 4'h1; bus.out_ready = 1'b1; step();
        check("fp_occ", 32'(occ), 32'd1);
        check("fp_head", 32'(bus.d_hamm), 32'h2D);
        check("fp_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0; step();
        check("fp_push_occ", 32'(occ), 32'd2);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; step();
        check("fp_pop_a", 32'(bus.d_hamm), 32'h07);
        step();
        check("fp_empty", 32'(occ), 32'd0);

        // Streaming all 16 nibbles with a standing occupancy of one.
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 4'h0; step();
        bus.out_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            bus.in_data = 4'(i);
            check("st_code", 32'(bus.d_hamm), 32'(code_tbl[i-1]));
            check("st_correct", 32'(correct(bus.d_hamm)), 32'(i-1));
            step();
            check("st_occ", 32'(occ), 32'd1);
        end
        bus.in_valid = 1'b0;
        check("st_last", 32'(bus.d_hamm), 32'h7F);
        step();
        check("st_drained", 32'(occ), 32'd0);

`ifdef ERR_INJECT_EN
        err_en = 1'b1; err_pos = 3'd4;
        bus.in_valid = 1'b1; bus.in_data = 4'hB; bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0; err_en = 1'b0;
        check("inj_code", 32'(bus.d_hamm), 32'h45);
        check("inj_correct", 32'(correct(bus.d_hamm)), 32'hB);
        err_en = 1'b1; err_pos = 3'd7; bus.in_valid = 1'b1; bus.in_data = 4'hC;
        bus.out_ready = 1'b1; step();
        bus.in_valid = 1'b0; err_en = 1'b0;
        check("inj_none", 32'(bus.d_hamm), 32'h61);
        step();
`endif

        // Asynchronous reset while two codewords are buffered.
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        bus.in_data = 4'h6; step();
        bus.in_data = 4'h9; step();
        bus.in_valid = 1'b0;
        check("ar_pre_occ", 32'(occ), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("ar_out_valid", 32'(bus.out_valid), 32'd0);
        check("ar_occ", 32'(occ), 32'd0);
        step();
        rst_n = 1'b1;
        check("ar_in_ready", 32'(bus.in_ready), 32'd1);
        check("ar_d_hamm", 32'(bus.d_hamm), 32'h00);
        bus.in_valid = 1'b1; bus.in_data = 4'hA; step();
        bus.in_valid = 1'b0;
        check("ar_first", 32'(bus.d_hamm), 32'h52);
        check("ar_first_occ", 32'(occ), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
